case_2_mul_pipe_hs: RTL

//  Parametrised, pipelined successor to the single-cycle 5x5->6 multiplier core.

---
 rtl/case_2_mul_pipe_hs.sv | 111 +++++++++++
 1 files changed

// File: rtl/case_2_mul_pipe_hs.sv
// Pipelined signed/unsigned multiplier with valid/ready flow control and full-pipeline stall.
// Optional clamping of the product to the result range is enabled by defining MUL_SAT_EN.
module case_2_mul_pipe_hs #(
   parameter int ID         = 1,
   parameter int NUM_STAGE  = 3,
   parameter int din0_WIDTH = 5,
   parameter int din1_WIDTH = 5,
   parameter int dout_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_vld,
   output logic                  in_rdy,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   input  logic                  sgn0,
   input  logic                  sgn1,
   output logic                  out_vld,
   input  logic                  out_rdy,
   output logic [dout_WIDTH-1:0] dout,
   output logic                  busy
);

   localparam int PW = din0_WIDTH + din1_WIDTH + 2;

   if (NUM_STAGE < 2 || NUM_STAGE > 6 || dout_WIDTH < 1 ||
       dout_WIDTH > din0_WIDTH + din1_WIDTH || ID < 0) begin : g_cfg_err
      $error("case_2_mul_pipe_hs: illegal parameter combination");
   end

   logic                  adv;
   logic [NUM_STAGE-1:0]  vld_q;
   logic [din0_WIDTH:0]   ext0_q, ext0_d;
   logic [din1_WIDTH:0]   ext1_q, ext1_d;
   logic [dout_WIDTH-1:0] res_q [1:NUM_STAGE-1];
   logic [dout_WIDTH-1:0] res_d;
   logic signed [PW-1:0]  prod;

   assign out_vld = vld_q[NUM_STAGE-1];
   assign dout    = res_q[NUM_STAGE-1];
   assign busy    = |vld_q;
   assign adv     = out_rdy | ~out_vld;
   assign in_rdy  = adv;

   always_comb begin
      ext0_d = {sgn0 & din0[din0_WIDTH-1], din0};
      ext1_d = {sgn1 & din1[din1_WIDTH-1], din1};
   end

   // Both extended operands are sign-extended to the full product width so the
   // multiply is exact for every signed/unsigned mode combination.
   always_comb begin
      prod = $signed({{(din1_WIDTH+1){ext0_q[din0_WIDTH]}}, ext0_q}) *
             $signed({{(din0_WIDTH+1){ext1_q[din1_WIDTH]}}, ext1_q});
   end

`ifdef MUL_SAT_EN
   localparam longint SMAX = (longint'(1) << (dout_WIDTH - 1)) - 1;
   localparam longint SMIN = -(longint'(1) << (dout_WIDTH - 1));
   localparam longint UMAX = (longint'(1) << dout_WIDTH) - 1;

   logic rsgn_q, rsgn_d;

   assign rsgn_d = sgn0 | sgn1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rsgn_q <= 1'b0;
      end else if (adv) begin
         rsgn_q <= rsgn_d;
      end
   end

   always_comb begin
      res_d = dout_WIDTH'(prod);
      if (rsgn_q) begin
         if (longint'(prod) > SMAX) begin
            res_d = dout_WIDTH'(SMAX);
         end else if (longint'(prod) < SMIN) begin
            res_d = dout_WIDTH'(SMIN);
         end
      end else if (longint'(prod) > UMAX) begin
         res_d = dout_WIDTH'(UMAX);
      end
   end
`else
   always_comb begin
      res_d = dout_WIDTH'(prod);
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q  <= '0;
         ext0_q <= '0;
         ext1_q <= '0;
         for (int unsigned i = 1; i < NUM_STAGE; i++) begin
            res_q[i] <= '0;
         end
      end else if (adv) begin
         vld_q    <= {vld_q[NUM_STAGE-2:0], in_vld};
         ext0_q   <= ext0_d;
         ext1_q   <= ext1_d;
         res_q[1] <= res_d;
         for (int unsigned i = 2; i < NUM_STAGE; i++) begin
            res_q[i] <= res_q[i-1];
         end
      end
   end

endmodule
